// File: rtl/ex_muldiv_seq.sv
// rtl/ex_muldiv_seq.sv - iterative unsigned mul/div sequencer for the EX stage
// Optional MULDIV_DIV0_FAST_EN: DIVU/REMU by zero go straight from IDLE to DONE.
module ex_muldiv_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] src1_i,
  input  logic [XLEN-1:0] src2_i,
  input  logic            flush_i,
  output logic            stall_req_o,
  output logic            busy_o,
  output logic            result_valid_o,
  output logic [XLEN-1:0] result_o
);

  localparam int CW = $clog2(XLEN + 1);
  localparam logic [CW-1:0] XLEN_C = CW'(XLEN);

`ifdef MULDIV_DIV0_FAST_EN
  localparam bit DIV0_FAST = 1'b1;
`else
  localparam bit DIV0_FAST = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      op_q, op_d;
  logic [XLEN-1:0] src1_q, src1_d;
  logic [XLEN-1:0] src2_q, src2_d;
  logic [XLEN:0]   hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] result_q, result_d;

  // Operand bits are picked by counter position, so the working register
  // can start cleared: multiplier LSB-first, dividend MSB-first.
  logic [CW-1:0]   mul_idx, div_idx;
  logic [XLEN-1:0] one_vec, mul_mask, div_mask;
  logic            mul_bit, div_bit;
  logic [XLEN:0]   mul_sum, div_shift, div_trial;
  logic            div_ge;

  assign one_vec   = {{(XLEN-1){1'b0}}, 1'b1};
  assign mul_idx   = XLEN_C - cnt_q;
  assign div_idx   = cnt_q - CW'(1);
  assign mul_mask  = one_vec << mul_idx;
  assign div_mask  = one_vec << div_idx;
  assign mul_bit   = |(src2_q & mul_mask);
  assign div_bit   = |(src1_q & div_mask);
  assign mul_sum   = hi_q + (mul_bit ? {1'b0, src1_q} : '0);
  assign div_shift = {hi_q[XLEN-1:0], div_bit};
  assign div_ge    = div_shift >= {1'b0, src2_q};
  assign div_trial = div_shift - {1'b0, src2_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      src1_q   <= '0;
      src2_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      src1_q   <= src1_d;
      src2_q   <= src2_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    src1_d   = src1_q;
    src2_d   = src2_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    cnt_d    = cnt_q;
    result_d = result_q;

    unique case (state_q)
      S_IDLE: begin
        if (start_i && !flush_i) begin
          op_d    = op_i;
          src1_d  = src1_i;
          src2_d  = src2_i;
          hi_d    = '0;
          lo_d    = '0;
          cnt_d   = XLEN_C;
          state_d = S_CALC;
          if (DIV0_FAST && op_i[1] && (src2_i == '0)) begin
            state_d  = S_DONE;
            result_d = op_i[0] ? src1_i : '1;
          end
        end
      end
      S_CALC: begin
        cnt_d = cnt_q - CW'(1);
        if (op_q[1]) begin
          hi_d = div_ge ? div_trial : div_shift;
          lo_d = {lo_q[XLEN-2:0], div_ge};
        end else begin
          hi_d = {1'b0, mul_sum[XLEN:1]};
          lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
        end
        // Odd opcodes (MULHU, REMU) return the upper half.
        if (cnt_q == CW'(1)) begin
          state_d  = S_DONE;
          result_d = op_q[0] ? hi_d[XLEN-1:0] : lo_d;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (flush_i) begin
      state_d  = S_IDLE;
      result_d = result_q;
    end
  end

  assign stall_req_o    = ((state_q == S_IDLE) && start_i && !flush_i) || (state_q == S_CALC);
  assign busy_o         = (state_q != S_IDLE);
  assign result_valid_o = (state_q == S_DONE);
  assign result_o       = result_q;

endmodule

// File: tb/tb_ex_muldiv_seq.sv
// tb/tb_ex_muldiv_seq.sv - randomized self-checking bench for ex_muldiv_seq
module tb_ex_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [1:0]  op_i;
  logic [31:0] src1_i;
  logic [31:0] src2_i;
  logic        flush_i;
  logic        stall_req_o;
  logic        busy_o;
  logic        result_valid_o;
  logic [31:0] result_o;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

`ifdef MULDIV_DIV0_FAST_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  ex_muldiv_seq #(.XLEN(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .start_i        (start_i),
    .op_i           (op_i),
    .src1_i         (src1_i),
    .src2_i         (src2_i),
    .flush_i        (flush_i),
    .stall_req_o    (stall_req_o),
    .busy_o         (busy_o),
    .result_valid_o (result_valid_o),
    .result_o       (result_o)
  );

  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = {32'h0, a} * {32'h0, b};
    case (op)
      2'd0:    return p[31:0];
      2'd1:    return p[63:32];
      2'd2:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_lat(input logic [1:0] op, input logic [31:0] b);
    return (FAST && op[1] && b == 0) ? 1 : 33;
  endfunction

  // Issues one op and follows it to its valid pulse (or a 60-cycle timeout, lat = -1).
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output int done_cyc, output int stall_bad);
    stall_bad = 0;
    lat       = -1;
    res       = '0;
    done_cyc  = -1;
    @(negedge clk);
    start_i = 1'b1; op_i = op; src1_i = a; src2_i = b;
    #1;
    if (stall_req_o !== 1'b1) stall_bad++;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      start_i = 1'b0;
      #1;
      if (result_valid_o === 1'b1) begin
        res = result_o; lat = c; done_cyc = cyc;
        if (stall_req_o !== 1'b0) stall_bad++;
        break;
      end else if (stall_req_o !== 1'b1) begin
        stall_bad++;
      end
    end
  endtask

  task automatic watch_no_valid(input int ncyc, output int seen);
    seen = 0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      if (result_valid_o !== 1'b0) seen++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start_i = 1'b0; op_i = '0; src1_i = '0; src2_i = '0; flush_i = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (stall_req_o !== 1'b0) begin n_fail++; $display("FAIL reset_stall got=%b exp=0", stall_req_o); end
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
    n_checks++; if (result_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", result_valid_o); end
    n_checks++; if (result_o !== 32'h0) begin n_fail++; $display("FAIL reset_result got=%h exp=0", result_o); end
    rst = 1'b0;
  endtask

  task automatic test_mul();
    logic [31:0] r; int lat, dc, sb;
    run_op(2'd0, 32'h0001_0000, 32'h0001_0000, r, lat, dc, sb);
    n_checks++; if (r !== 32'h0 || lat != 33) begin n_fail++; $display("FAIL mul got=%h lat=%0d exp=00000000 lat=33", r, lat); end
    n_checks++; if (sb != 0) begin n_fail++; $display("FAIL mul_stall bad_cycles=%0d exp=0", sb); end
    run_op(2'd1, 32'h0001_0000, 32'h0001_0000, r, lat, dc, sb);
    n_checks++; if (r !== 32'h1 || lat != 33) begin n_fail++; $display("FAIL mulhu got=%h lat=%0d exp=00000001 lat=33", r, lat); end
    @(negedge clk);
    n_checks++; if (result_valid_o !== 1'b0 || result_o !== 32'h1) begin
      n_fail++; $display("FAIL mulhu_after_done valid=%b res=%h exp valid=0 res=00000001", result_valid_o, result_o);
    end
  endtask

  task automatic test_div();
    logic [31:0] r; int lat, dc, sb;
    run_op(2'd2, 32'd100, 32'd7, r, lat, dc, sb);
    n_checks++; if (r !== 32'd14 || lat != 33) begin n_fail++; $display("FAIL divu got=%0d lat=%0d exp=14 lat=33", r, lat); end
    n_checks++; if (sb != 0) begin n_fail++; $display("FAIL divu_stall bad_cycles=%0d exp=0", sb); end
    run_op(2'd3, 32'd100, 32'd7, r, lat, dc, sb);
    n_checks++; if (r !== 32'd2 || lat != 33) begin n_fail++; $display("FAIL remu got=%0d lat=%0d exp=2 lat=33", r, lat); end
  endtask

  task automatic test_div0();
    logic [31:0] r; int lat, dc, sb;
    run_op(2'd2, 32'h1234_5678, 32'h0, r, lat, dc, sb);
    n_checks++; if (r !== 32'hFFFF_FFFF || lat != exp_lat(2'd2, 0)) begin
      n_fail++; $display("FAIL divu_zero got=%h lat=%0d exp=ffffffff lat=%0d", r, lat, exp_lat(2'd2, 0));
    end
    n_checks++; if (sb != 0) begin n_fail++; $display("FAIL divu_zero_stall bad_cycles=%0d exp=0", sb); end
    run_op(2'd3, 32'h1234_5678, 32'h0, r, lat, dc, sb);
    n_checks++; if (r !== 32'h1234_5678 || lat != exp_lat(2'd3, 0)) begin
      n_fail++; $display("FAIL remu_zero got=%h lat=%0d exp=12345678 lat=%0d", r, lat, exp_lat(2'd3, 0));
    end
  endtask

  task automatic test_random();
    logic [31:0] r, a, b; logic [1:0] op; int lat, dc, sb;
    for (int i = 0; i < 24; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'h0;
        1:       b = $urandom_range(1, 255);
        default: b = $urandom;
      endcase
      run_op(op, a, b, r, lat, dc, sb);
      n_checks++; if (r !== model(op, a, b) || lat != exp_lat(op, b) || sb != 0) begin
        n_fail++;
        $display("FAIL random[%0d] op=%0d a=%h b=%h got=%h lat=%0d stallbad=%0d exp=%h lat=%0d",
                 i, op, a, b, r, lat, sb, model(op, a, b), exp_lat(op, b));
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] r; int lat, dc, sb, seen;
    run_op(2'd0, 32'd3, 32'd5, r, lat, dc, sb);
    n_checks++; if (r !== 32'd15) begin n_fail++; $display("FAIL pre_reset_mul got=%0d exp=15", r); end
    @(negedge clk);
    start_i = 1'b1; op_i = 2'd0; src1_i = 32'hDEAD_BEEF; src2_i = 32'h1234_5678;
    repeat (10) begin @(negedge clk); start_i = 1'b0; end
    #2 rst = 1'b1;
    #1;
    n_checks++; if (busy_o !== 1'b0 || result_o !== 32'h0 || stall_req_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid busy=%b res=%h stall=%b exp busy=0 res=0 stall=0", busy_o, result_o, stall_req_o);
    end
    @(negedge clk);
    rst = 1'b0;
    watch_no_valid(40, seen);
    n_checks++; if (seen != 0) begin n_fail++; $display("FAIL reset_mid_valid pulses=%0d exp=0", seen); end
  endtask

  task automatic test_flush();
    int seen;
    @(negedge clk);
    start_i = 1'b1; op_i = 2'd2; src1_i = 32'd100; src2_i = 32'd7;
    repeat (5) begin @(negedge clk); start_i = 1'b0; end
    flush_i = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL flush_calc busy=%b exp=0", busy_o); end
    flush_i = 1'b0;
    watch_no_valid(40, seen);
    n_checks++; if (seen != 0) begin n_fail++; $display("FAIL flush_calc_valid pulses=%0d exp=0", seen); end
    @(negedge clk);
    start_i = 1'b1; flush_i = 1'b1; op_i = 2'd0; src1_i = 32'd9; src2_i = 32'd9;
    #1;
    n_checks++; if (stall_req_o !== 1'b0) begin n_fail++; $display("FAIL flush_start_stall got=%b exp=0", stall_req_o); end
    @(posedge clk); #1;
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL flush_start_busy got=%b exp=0", busy_o); end
    @(negedge clk);
    start_i = 1'b0; flush_i = 1'b0;
    watch_no_valid(40, seen);
    n_checks++; if (seen != 0) begin n_fail++; $display("FAIL flush_start_valid pulses=%0d exp=0", seen); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r1, r2, a1, b1, a2, b2; int l1, l2, d1, d2, s1, s2;
    a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = $urandom_range(1, 32'hFFFF);
    run_op(2'd0, a1, b1, r1, l1, d1, s1);
    run_op(2'd2, a2, b2, r2, l2, d2, s2);
    n_checks++; if (r1 !== model(2'd0, a1, b1)) begin n_fail++; $display("FAIL b2b_mul got=%h exp=%h", r1, model(2'd0, a1, b1)); end
    n_checks++; if (r2 !== model(2'd2, a2, b2)) begin n_fail++; $display("FAIL b2b_divu got=%h exp=%h", r2, model(2'd2, a2, b2)); end
    n_checks++; if (l1 < 0 || l2 < 0 || (d2 - d1) != 34) begin
      n_fail++; $display("FAIL b2b_spacing got=%0d exp=34", d2 - d1);
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_div0();
    test_random();
    test_reset_mid();
    test_flush();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_muldiv_seq.md
# ex_muldiv_seq

Multi-cycle multiply/divide sequencer attached to the execute stage. It accepts an M-extension operation from the EX stage and runs an iterative shift-add multiplier or restoring divider for XLEN cycles. While it runs, it holds the pipeline with a stall request, then presents the result for exactly one cycle. Single-cycle ALU operations never touch this block; EX selects between the ALU result and `result_o` using `result_valid_o`.

## Interface
- `XLEN`, default 32: operand and result width; iteration count equals `XLEN`.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start_i`  in  1  EX holds a mul/div instruction; sampled only in IDLE.
- `op_i`  in  2  operation: 00 MUL (low product), 01 MULHU (high product, unsigned), 10 DIVU, 11 REMU.
- `src1_i`  in  XLEN  operand A (multiplicand / dividend).
- `src2_i`  in  XLEN  operand B (multiplier / divisor).
- `flush_i`  in  1  pipeline flush; aborts any operation.
- `stall_req_o`  out  1  request to freeze PC, IF/ID and ID/EX.
- `busy_o`  out  1  state is not IDLE.
- `result_valid_o`  out  1  `result_o` valid this cycle (one-cycle pulse).
- `result_o`  out  XLEN  operation result.

## Operation
- States:
  - IDLE: waits for `start_i`.
  - CALC: runs the iterations.
  - DONE: presents the result.
- IDLE:
  - If `start_i` is high and `flush_i` is low, latch `op_i`, `src1_i` and `src2_i`.
  - Clear the 2·XLEN working register and load the iteration counter with `XLEN`.
  - Go to CALC.
- CALC, MUL/MULHU:
  - Each cycle, if the multiplier LSB is 1, add the multiplicand into the upper half of the accumulator.
  - Then shift the {carry, accumulator} pair right by 1.
  - The accumulator is XLEN+1 bits wide to hold the carry.
- CALC, DIVU/REMU (restoring division):
  - Shift the {remainder, quotient} pair left by 1.
  - Trial-subtract the divisor from the remainder.
  - If the trial result is non-negative, keep it and set the quotient LSB to 1; otherwise restore and set it to 0.
- Counter:
  - Decrements once per CALC cycle.
  - When it reaches 0 at the end of a CALC cycle, go to DONE.
- DONE:
  - `result_valid_o` is 1.
  - `result_o` selects: low product (MUL), high product (MULHU), quotient (DIVU) or remainder (REMU).
  - Unconditionally return to IDLE; `start_i` is ignored in DONE.
- Divide by zero, both paths: quotient = all ones, remainder = `src1`, per the RISC-V M extension.
- Arithmetic: all unsigned, modulo 2^XLEN per half; no overflow flags.
- Flush:
  - `flush_i` in any state forces IDLE on the next edge.
  - No `result_valid_o` is produced, and working registers are not cleared.
  - Flush has priority over start.

## Timing
- Reset (async): state = IDLE.
  - Outputs: `stall_req_o` = 0, `busy_o` = 0, `result_valid_o` = 0, `result_o` = 0.
  - Counter and working registers are cleared.
- `stall_req_o` (combinational) = (IDLE && `start_i` && !`flush_i`) || CALC.
  - It is asserted in the same cycle as `start_i`, so the instruction stays in EX.
  - It is low in DONE, so the pipeline advances and captures `result_o`.
- Latency:
  - `start_i` seen in cycle 0.
  - CALC occupies cycles 1..XLEN.
  - DONE occurs in cycle XLEN+1 (cycle 33 for XLEN = 32).
- `result_o` is registered and stable for the whole DONE cycle; it holds its value after DONE.
- Back-to-back ops: the following instruction raises `start_i` in the cycle after DONE and is accepted there, since IDLE is reached.
- Reset mid-CALC: returns to IDLE immediately; the result is lost.

## Configuration
- `MULDIV_DIV0_FAST_EN`:
  - Defined: DIVU/REMU with `src2` = 0 skip CALC. IDLE→DONE directly, with `result_valid_o` in cycle 1.
  - Not defined: the full XLEN iterations run and give the same values through restoring division.
- The results are identical in both builds; only the latency differs.
- When the fast path is active, `stall_req_o` is high only in cycle 0.

## Test plan
- Reset mid-CALC:
  - Assert `rst` at cycle 10 of a MUL.
  - Required: `busy_o` = 0, `result_o` = 0 immediately, and no `result_valid_o` afterwards.
- MUL:
  - Inputs: `src1` = 0x0001_0000, `src2` = 0x0001_0000.
  - Required: `result_valid_o` in cycle 33 with `result_o` = 0x0000_0000.
  - Repeat with `op_i` = MULHU: `result_o` = 0x0000_0001.
- DIVU/REMU:
  - Inputs: 100 / 7.
  - Required: quotient 14, remainder 2.
  - `stall_req_o` is high in cycles 0–32 and low in cycle 33.
- Divide by zero:
  - Inputs: 0x1234_5678 / 0.
  - Required: DIVU gives 0xFFFF_FFFF and REMU gives 0x1234_5678.
  - Valid in cycle 1 with `MULDIV_DIV0_FAST_EN` defined, cycle 33 without.
- Flush:
  - Assert `flush_i` at CALC cycle 5.
  - Required: IDLE on the next edge and no valid pulse.
  - Assert `flush_i` together with `start_i` in IDLE: the start is ignored and `stall_req_o` stays 0.
- Back-to-back:
  - Issue MUL then DIVU, with the second `start_i` in the cycle after DONE.
  - Required: two valid pulses 34 cycles apart, each carrying the correct result.
